// File: rtl/half_duplex_uart_responder_if.sv
// Host-side byte interface of the half-duplex UART responder: TX push handshake,
// RX byte/status pulses and the busy flag.
interface half_duplex_uart_responder_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_frame_err;
   logic       busy;

   modport master (
      output tx_data, tx_valid,
      input  tx_ready, rx_data, rx_valid, rx_frame_err, busy
   );

   modport slave (
      input  tx_data, tx_valid,
      output tx_ready, rx_data, rx_valid, rx_frame_err, busy
   );
endinterface

// File: rtl/half_duplex_uart_responder.sv
// ESC-side endpoint of a single-wire half-duplex UART: receives host bytes, queues
// reply bytes and drives them after a turnaround guard, blanking its own echo.
module half_duplex_uart_responder #(
   parameter int unsigned CLK_FREQ_HZ     = 72_000_000,
   parameter int unsigned BAUD_RATE       = 115200,
   parameter int unsigned TURNAROUND_BITS = 2,
   parameter int unsigned FIFO_DEPTH      = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic serial_rx_in,
   output logic serial_tx_out,
   output logic serial_tx_oe,
   half_duplex_uart_responder_if.slave bus
);
   localparam int unsigned CPB      = CLK_FREQ_HZ / BAUD_RATE;
   localparam int unsigned CW       = $clog2(CPB);
   localparam int unsigned IDLE_MAX = TURNAROUND_BITS * CPB;
   localparam int unsigned IW       = $clog2(IDLE_MAX + 1);
   localparam int unsigned BW       = $clog2(CPB + 1);
   localparam int unsigned AW       = $clog2(FIFO_DEPTH);
   localparam int unsigned NW       = AW + 1;

   localparam logic [CW-1:0] BIT_LAST   = CW'(CPB - 1);
   localparam logic [CW-1:0] HALF_LAST  = CW'(CPB / 2 - 1);
   localparam logic [IW-1:0] IDLE_SAT   = IW'(IDLE_MAX);
   localparam logic [BW-1:0] BLANK_LOAD = BW'(CPB);
   localparam logic [NW-1:0] FIFO_FULL  = NW'(FIFO_DEPTH);

   localparam logic [2:0] TX_IDLE  = 3'd0;
   localparam logic [2:0] TX_GUARD = 3'd1;
   localparam logic [2:0] TX_START = 3'd2;
   localparam logic [2:0] TX_DATA  = 3'd3;
   localparam logic [2:0] TX_STOP  = 3'd4;

   localparam logic [2:0] RX_IDLE  = 3'd0;
   localparam logic [2:0] RX_START = 3'd1;
   localparam logic [2:0] RX_DATA  = 3'd2;
   localparam logic [2:0] RX_STOP  = 3'd3;
   localparam logic [2:0] RX_WAIT  = 3'd4;

   logic          rx_meta, rx_sync, rx_prev;
   logic [2:0]    rx_state;
   logic [CW-1:0] rx_cnt;
   logic [2:0]    rx_idx;
   logic [7:0]    rx_shift;
   logic [IW-1:0] idle_cnt;
   logic [BW-1:0] blank_cnt;

   logic [2:0]    tx_state;
   logic [CW-1:0] tx_cnt;
   logic [2:0]    tx_idx;
   logic [7:0]    tx_shift;
   logic          tx_bit;

   logic [7:0]    fifo_mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [NW-1:0] fifo_cnt;

   logic start_det, idle_sat, fifo_nonempty, tx_bit_end, launch, push;

   // launch folds GUARD->START into the IDLE exit so a saturated line drives oe one cycle after a push
   always_comb begin
      start_det     = rx_prev && !rx_sync && (rx_state == RX_IDLE) && !serial_tx_oe && (blank_cnt == '0);
      idle_sat      = (idle_cnt == IDLE_SAT);
      fifo_nonempty = (fifo_cnt != '0);
      tx_bit_end    = (tx_cnt == BIT_LAST);
      push          = bus.tx_valid && bus.tx_ready;
      launch        = fifo_nonempty &&
                      ((((tx_state == TX_IDLE) || (tx_state == TX_GUARD)) && idle_sat && !start_det) ||
                       ((tx_state == TX_STOP) && tx_bit_end));
   end

   assign bus.tx_ready  = (fifo_cnt != FIFO_FULL);
   assign bus.busy      = (tx_state != TX_IDLE) || fifo_nonempty;
   assign serial_tx_out = serial_tx_oe ? tx_bit : 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= serial_rx_in;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_state         <= RX_IDLE;
         rx_cnt           <= '0;
         rx_idx           <= '0;
         rx_shift         <= '0;
         bus.rx_data      <= '0;
         bus.rx_valid     <= 1'b0;
         bus.rx_frame_err <= 1'b0;
      end else begin
         bus.rx_valid     <= 1'b0;
         bus.rx_frame_err <= 1'b0;
         case (rx_state)
            RX_IDLE: if (start_det) begin
               rx_state <= RX_START;
               rx_cnt   <= '0;
            end
            RX_START: if (rx_cnt == HALF_LAST) begin
               rx_cnt   <= '0;
               rx_idx   <= '0;
               rx_state <= rx_sync ? RX_IDLE : RX_DATA;
            end else begin
               rx_cnt <= rx_cnt + 1'b1;
            end
            RX_DATA: if (rx_cnt == BIT_LAST) begin
               rx_cnt   <= '0;
               rx_shift <= {rx_sync, rx_shift[7:1]};
               rx_idx   <= rx_idx + 1'b1;
               if (rx_idx == 3'd7) rx_state <= RX_STOP;
            end else begin
               rx_cnt <= rx_cnt + 1'b1;
            end
            RX_STOP: if (rx_cnt == BIT_LAST) begin
               rx_cnt   <= '0;
               rx_state <= RX_WAIT;
               if (rx_sync) begin
                  bus.rx_data  <= rx_shift;
                  bus.rx_valid <= 1'b1;
               end else begin
                  bus.rx_frame_err <= 1'b1;
               end
            end else begin
               rx_cnt <= rx_cnt + 1'b1;
            end
            RX_WAIT: if (rx_sync) rx_state <= RX_IDLE;
            default: rx_state <= RX_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idle_cnt  <= '0;
         blank_cnt <= '0;
      end else begin
         if (rx_sync && (rx_state == RX_IDLE) && !serial_tx_oe) begin
            if (!idle_sat) idle_cnt <= idle_cnt + 1'b1;
         end else begin
            idle_cnt <= '0;
         end
         if (serial_tx_oe)         blank_cnt <= BLANK_LOAD;
         else if (blank_cnt != '0) blank_cnt <= blank_cnt - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state     <= TX_IDLE;
         tx_cnt       <= '0;
         tx_idx       <= '0;
         tx_shift     <= '0;
         tx_bit       <= 1'b1;
         serial_tx_oe <= 1'b0;
      end else if (launch) begin
         tx_state     <= TX_START;
         tx_cnt       <= '0;
         tx_shift     <= fifo_mem[rd_ptr];
         tx_bit       <= 1'b0;
         serial_tx_oe <= 1'b1;
      end else begin
         case (tx_state)
            TX_IDLE:  if (fifo_nonempty) tx_state <= TX_GUARD;
            TX_GUARD: if (start_det) tx_state <= TX_IDLE;
            TX_START: if (tx_bit_end) begin
               tx_cnt   <= '0;
               tx_idx   <= '0;
               tx_bit   <= tx_shift[0];
               tx_state <= TX_DATA;
            end else begin
               tx_cnt <= tx_cnt + 1'b1;
            end
            TX_DATA: if (tx_bit_end) begin
               tx_cnt <= '0;
               if (tx_idx == 3'd7) begin
                  tx_bit   <= 1'b1;
                  tx_state <= TX_STOP;
               end else begin
                  tx_bit   <= tx_shift[1];
                  tx_shift <= tx_shift >> 1;
                  tx_idx   <= tx_idx + 1'b1;
               end
            end else begin
               tx_cnt <= tx_cnt + 1'b1;
            end
            TX_STOP: if (tx_bit_end) begin
               tx_cnt       <= '0;
               tx_state     <= TX_IDLE;
               serial_tx_oe <= 1'b0;
            end else begin
               tx_cnt <= tx_cnt + 1'b1;
            end
            default: tx_state <= TX_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= bus.tx_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push)   wr_ptr <= wr_ptr + 1'b1;
         if (launch) rd_ptr <= rd_ptr + 1'b1;
         case ({push, launch})
            2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
            2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end
endmodule

// File: tb/tb_half_duplex_uart_responder.sv
// Directed bench for half_duplex_uart_responder at 16 clocks per bit, with the
// pad modelled as the DUT driver when oe=1 and the host driver otherwise.
module tb_half_duplex_uart_responder;
   localparam int unsigned CPB = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic host_line = 1'b1;
   logic host_active = 1'b0;
   logic line;
   logic serial_tx_out, serial_tx_oe;

   half_duplex_uart_responder_if bus ();

   half_duplex_uart_responder #(
      .CLK_FREQ_HZ(1_600_000),
      .BAUD_RATE(100_000),
      .TURNAROUND_BITS(2),
      .FIFO_DEPTH(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .serial_rx_in(line),
      .serial_tx_out(serial_tx_out),
      .serial_tx_oe(serial_tx_oe),
      .bus(bus)
   );

   assign line = serial_tx_oe ? serial_tx_out : host_line;

   always #5 clk = ~clk;

   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned cyc = 0;
   int unsigned valid_cnt = 0, err_cnt = 0, both_cnt = 0, conflict_cnt = 0;
   logic [7:0]  last_data = '0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.rx_valid) begin
         valid_cnt <= valid_cnt + 1;
         last_data <= bus.rx_data;
      end
      if (bus.rx_frame_err) err_cnt <= err_cnt + 1;
      if (bus.rx_valid && bus.rx_frame_err) both_cnt <= both_cnt + 1;
      if (host_active && serial_tx_oe) conflict_cnt <= conflict_cnt + 1;
   end

   initial begin
      #300_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic host_frame(input logic [7:0] b, input logic stop_bit);
      logic [9:0] f;
      f = {stop_bit, b, 1'b0};
      @(negedge clk);
      host_active = 1'b1;
      for (int i = 0; i < 10; i++) begin
         host_line = f[i];
         repeat (CPB) @(negedge clk);
      end
      host_line   = 1'b1;
      host_active = 1'b0;
   endtask

   task automatic push_byte(input logic [7:0] b, output logic ok, output int unsigned acc);
      int unsigned n;
      n = 0;
      @(negedge clk);
      bus.tx_data  = b;
      bus.tx_valid = 1'b1;
      while (!bus.tx_ready && n < 400) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      #1;
      acc = cyc;
      bus.tx_valid = 1'b0;
      ok = (n < 400);
   endtask

   task automatic wait_oe(input int unsigned limit, output int unsigned n);
      n = 0;
      while (!serial_tx_oe && n < limit) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic capture_run(output logic [49:0] bits, output int unsigned len);
      int unsigned idx;
      bits = '0;
      len  = 0;
      while (serial_tx_oe && len < 2000) begin
         idx = len / CPB;
         if ((len % CPB) == CPB / 2 && idx < 50) bits[idx] = serial_tx_out;
         @(posedge clk);
         #1;
         len++;
      end
   endtask

   logic        ok, ok5;
   int unsigned acc, acc5, n, n5, rise5, len, len5, v0, e0, c0, lat, oe_seen;
   logic [49:0] bits, bits50;
   logic [7:0]  hello [5];

   initial begin
      hello = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
      bus.tx_valid = 1'b0;
      bus.tx_data  = '0;

      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_oe", serial_tx_oe, 1'b0);
      check_eq("rst_tx_out", serial_tx_out, 1'b1);
      check_eq("rst_rx_valid", bus.rx_valid, 1'b0);
      check_eq("rst_frame_err", bus.rx_frame_err, 1'b0);
      check_eq("rst_rx_data", bus.rx_data, 8'h00);
      check_eq("rst_tx_ready", bus.tx_ready, 1'b1);
      check_eq("rst_busy", bus.busy, 1'b0);
      @(negedge clk) rst = 1'b0;
      repeat (4 * CPB) @(posedge clk);

      // good frame 0x30
      v0 = valid_cnt; e0 = err_cnt;
      host_frame(8'h30, 1'b1);
      repeat (8) @(posedge clk);
      #1;
      check_eq("rx30_valid", valid_cnt - v0, 1);
      check_eq("rx30_err", err_cnt - e0, 0);
      check_eq("rx30_data", last_data, 8'h30);

      // stop bit low, then good 0xA5
      v0 = valid_cnt; e0 = err_cnt;
      host_frame(8'h55, 1'b0);
      repeat (2 * CPB) @(posedge clk);
      #1;
      check_eq("bad55_err", err_cnt - e0, 1);
      check_eq("bad55_valid", valid_cnt - v0, 0);
      check_eq("bad55_data_held", bus.rx_data, 8'h30);
      v0 = valid_cnt;
      host_frame(8'hA5, 1'b1);
      repeat (8) @(posedge clk);
      #1;
      check_eq("rxa5_valid", valid_cnt - v0, 1);
      check_eq("rxa5_data", last_data, 8'hA5);

      // 3-cycle glitch is rejected at the start re-check
      v0 = valid_cnt; e0 = err_cnt;
      @(negedge clk) host_line = 1'b0;
      repeat (3) @(negedge clk);
      host_line = 1'b1;
      repeat (12 * CPB) @(posedge clk);
      #1;
      check_eq("glitch_no_pulse", (valid_cnt - v0) + (err_cnt - e0), 0);

      // idle line: push 0xF4
      repeat (3 * CPB) @(posedge clk);
      v0 = valid_cnt;
      push_byte(8'hF4, ok, acc);
      check_eq("f4_push_ok", ok, 1'b1);
      check_eq("f4_oe_at_push", serial_tx_oe, 1'b0);
      @(posedge clk);
      #1;
      check_eq("f4_oe_rise", serial_tx_oe, 1'b1);
      capture_run(bits, len);
      check_eq("f4_oe_len", len, 10 * CPB);
      check_eq("f4_bits", bits[9:0], 10'h3E8);
      repeat (2 * CPB) @(posedge clk);
      #1;
      check_eq("f4_no_echo", valid_cnt - v0, 0);

      // push right after a host frame: guard must elapse first
      repeat (3 * CPB) @(posedge clk);
      v0 = valid_cnt;
      host_frame(8'h3C, 1'b1);
      push_byte(8'hF4, ok, acc);
      oe_seen = 0;
      for (int i = 0; i < 20; i++) begin
         if (serial_tx_oe) oe_seen++;
         @(posedge clk);
         #1;
      end
      check_eq("guard_hold", oe_seen, 0);
      wait_oe(100, n);
      lat = 20 + n;
      check_eq("guard_oe_rise", serial_tx_oe, 1'b1);
      check_eq("guard_lat_window", (lat >= 22 && lat <= 32), 1'b1);
      capture_run(bits, len);
      check_eq("guard_bits", bits[9:0], {1'b1, 8'hF4, 1'b0});
      check_eq("guard_rx3c_valid", valid_cnt - v0, 1);
      check_eq("guard_rx3c_data", last_data, 8'h3C);

      // host start during GUARD defers the queued byte
      repeat (CPB + 2) @(posedge clk);
      c0 = conflict_cnt;
      push_byte(8'h11, ok, acc);
      host_frame(8'h22, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      check_eq("defer_no_conflict", conflict_cnt - c0, 0);
      check_eq("defer_rx22_data", last_data, 8'h22);
      wait_oe(200, n);
      check_eq("defer_oe_rise", serial_tx_oe, 1'b1);
      capture_run(bits, len);
      check_eq("defer_bits", bits[9:0], {1'b1, 8'h11, 1'b0});

      // five back-to-back pushes after reset (guard not yet met)
      @(negedge clk) rst = 1'b1;
      @(negedge clk) rst = 1'b0;
      v0 = valid_cnt;
      for (int i = 0; i < 4; i++) push_byte(hello[i], ok, acc);
      check_eq("fill_tx_ready", bus.tx_ready, 1'b0);
      check_eq("fill_busy", bus.busy, 1'b1);
      fork
         push_byte(hello[4], ok5, acc5);
         begin
            wait_oe(200, n5);
            rise5 = cyc;
            capture_run(bits50, len5);
         end
      join
      check_eq("push5_ok", ok5, 1'b1);
      check_eq("push5_after_pop", acc5 - rise5, 1);
      check_eq("burst_len", len5, 50 * CPB);
      for (int i = 0; i < 5; i++)
         check_eq($sformatf("burst_frame%0d", i), bits50[i*10 +: 10], {1'b1, hello[i], 1'b0});
      repeat (2 * CPB) @(posedge clk);
      #1;
      check_eq("burst_no_echo", valid_cnt - v0, 0);

      // reset mid-DATA
      push_byte(8'h5A, ok, acc);
      push_byte(8'h5B, ok, acc);
      push_byte(8'h5C, ok, acc);
      wait_oe(200, n);
      check_eq("mid_oe_rise", serial_tx_oe, 1'b1);
      repeat (3 * CPB) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      @(posedge clk);
      #1;
      check_eq("mid_rst_oe", serial_tx_oe, 1'b0);
      check_eq("mid_rst_busy", bus.busy, 1'b0);
      check_eq("mid_rst_ready", bus.tx_ready, 1'b1);
      check_eq("mid_rst_tx_out", serial_tx_out, 1'b1);
      @(negedge clk) rst = 1'b0;
      oe_seen = 0;
      for (int i = 0; i < 6 * CPB; i++) begin
         @(posedge clk);
         #1;
         if (serial_tx_oe) oe_seen++;
      end
      check_eq("flush_no_tx", oe_seen, 0);
      check_eq("flush_busy", bus.busy, 1'b0);
      check_eq("never_both_pulses", both_cnt, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/half_duplex_uart_responder.md
# half_duplex_uart_responder

ESC-side endpoint of the single-wire half-duplex serial link driven by `uart_passthrough_bridge`. It receives bytes the bridge forwards from the PC and transmits reply bytes back on the same wire. It enforces a turnaround guard before driving the line and blanks its own echo. It serves as a synthesizable ESC/bootloader model for loopback builds and bench work, and as the device-side front end for a future on-FPGA BLHeli responder.

## Interface
- `CLK_FREQ_HZ`, 72_000_000, system clock frequency.
- `BAUD_RATE`, 115200, line rate. CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE (integer divide; 625 at defaults).
- `TURNAROUND_BITS`, 2, bit-times of continuous line idle required before the block may assert `serial_tx_oe`.
- `FIFO_DEPTH`, 4, TX byte FIFO depth (power of two, ≥2).

Ports:
- `clk` in 1: system clock. Single clock domain.
- `rst` in 1: synchronous, active-high reset.
- `serial_rx_in` in 1: line value read from the pad. Asynchronous; the block synchronizes it.
- `serial_tx_out` out 1: value to drive on the line. Constant 1 whenever `serial_tx_oe`=0.
- `serial_tx_oe` out 1: pad output enable. 1 = the block owns the line.
- `rx_data` out 8: last received byte. Valid while `rx_valid`=1.
- `rx_valid` out 1: one-cycle pulse per good frame.
- `rx_frame_err` out 1: one-cycle pulse when the stop bit samples low.
- `tx_data` in 8: byte to queue for transmission.
- `tx_valid` in 1: push request.
- `tx_ready` out 1: FIFO not full. A push occurs on a cycle where `tx_valid` and `tx_ready` are both 1.
- `busy` out 1: 1 while the TX FSM is not in IDLE, or the FIFO is non-empty.

## Operation
- Reset values:
  - `serial_tx_oe`=0, `serial_tx_out`=1.
  - `rx_valid`=0, `rx_frame_err`=0, `rx_data`=0.
  - `tx_ready`=1, `busy`=0.
  - FIFO empty. Idle counter cleared.
- RX path:
  - Input passes through a 2-FF synchronizer. A falling edge on the synchronized line starts a frame.
  - Start bit is re-checked at CLKS_PER_BIT/2. If the line is high there, the edge is a glitch: return to idle with no pulse.
  - Data bits are sampled at mid-bit, LSB first.
  - Stop bit is sampled at mid-bit. High → `rx_data` updates and `rx_valid` pulses. Low → `rx_frame_err` pulses and `rx_data` is unchanged.
  - After any stop sample, RX waits for the line to be high before re-arming.
- Echo blanking: RX start detection is inhibited while `serial_tx_oe`=1 and for one full bit-time after it falls.
- Idle counter: counts cycles in which the synchronized line is high, RX is idle, and `serial_tx_oe`=0. It clears on any low sample or RX activity and saturates at TURNAROUND_BITS*CLKS_PER_BIT.
- TX FSM states: IDLE, GUARD, START, DATA, STOP.
  - IDLE → GUARD when the FIFO is non-empty.
  - GUARD → START when the idle counter is saturated. This happens the same cycle if it is already saturated.
  - GUARD → IDLE if RX detects a start edge. The host owns the line; the byte stays queued.
  - START: pop the FIFO, assert `serial_tx_oe`, drive 0 for one bit-time.
  - DATA: 8 bit-times, LSB first.
  - STOP: drive 1 for one bit-time. At the end of STOP:
    - FIFO non-empty → START directly, `serial_tx_oe` stays 1, no guard.
    - FIFO empty → IDLE, `serial_tx_oe`=0 on the next cycle.
- FIFO:
  - Push while full is ignored (`tx_ready`=0).
  - Push and pop in the same cycle are both honoured; occupancy is unchanged.
- Reset mid-frame: `serial_tx_oe` drops on the cycle after `rst` is sampled high, the FIFO is flushed, and RX is abandoned with no pulse.

## Timing
- Bit-time is exactly CLKS_PER_BIT cycles. A transmitted frame holds `serial_tx_oe`=1 for exactly 10*CLKS_PER_BIT cycles per byte.
- Push-to-`serial_tx_oe`: 1 cycle when the idle counter is already saturated. Otherwise it is (remaining guard) + 1 cycle.
- RX latency: `rx_valid` pulses 3 cycles after the mid-stop sample point (2 sync + 1 register). That is ≈9.5 bit-times + 3 cycles after the start edge on the pin.
- `rx_valid` and `rx_frame_err` are never both high in the same cycle.
- `tx_ready` deasserts the cycle after the push that fills the FIFO.

## Test plan
- Pin frame 0x30, 8680 ns bits → `rx_valid` pulses once with `rx_data`=0x30 and no `rx_frame_err`.
- Frame 0x55 with stop bit forced low → `rx_frame_err` pulses once, `rx_valid` stays 0, `rx_data` is unchanged. A following good 0xA5 is received correctly.
- Line idle, push 0xF4 → `serial_tx_oe` rises 1 cycle later; line carries 0,0,0,1,0,1,1,1,1,1 at 625-cycle bits; `serial_tx_oe` falls after 6250 cycles.
- Push 0xF4 within 1 bit-time after an RX stop bit → `serial_tx_oe` is not asserted until 2*625 idle cycles have elapsed. A host start edge during GUARD defers TX until the line is idle again.
- Push 0x48,0x45,0x4C,0x4C,0x4F back-to-back → 4 are accepted, `tx_ready` goes low, and the 5th is taken after the first pop. All five go out contiguously with `serial_tx_oe` held high, and no echo produces `rx_valid`.
- Assert `rst` mid-DATA → `serial_tx_oe`=0 next cycle, `busy`=0, and the FIFO is empty after reset.
